// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch-stage control, instruction-memory and IF/ID
// signals into one bundle.
//   master : the fetch stage (drives imem_addr and the IF/ID outputs)
//   slave  : the surrounding pipeline / memory (drives control and imem_rdata)
// Signals:
//   stall, br_taken, br_target, halt  control from downstream stages
//   imem_addr / imem_rdata            synchronous instruction memory port
//   id_inst, id_pc1, id_valid         IF/ID register contents
//   halted                            stage frozen after halt
interface fetch_stage_if #(
  parameter int PC_W = 16
);
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            halt;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic [15:0]     id_inst;
  logic [PC_W-1:0] id_pc1;
  logic            id_valid;
  logic            halted;

  modport master (
    input  stall, br_taken, br_target, halt, imem_rdata,
    output imem_addr, id_inst, id_pc1, id_valid, halted
  );

  modport slave (
    output stall, br_taken, br_target, halt, imem_rdata,
    input  imem_addr, id_inst, id_pc1, id_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Holds the PC, addresses the synchronous
// instruction memory and loads the IF/ID register feeding decode. Handles
// stall, branch redirect (flush with a NOP bubble) and halt.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset
//   bus    fetch_stage_if.master (control in, imem port, IF/ID out, halted)
// Parameters: PC_W, RESET_PC, NOP_INST (bubble encoding).
// Build option: IF_HALT_DETECT_EN -- when defined, fetch pre-decodes the
// captured word and stops fetching past an HLT until a redirect arrives.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_INST = 16'hC070
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;      // next address to issue
  logic [PC_W-1:0] f_pc_q;    // address whose word is in flight
  logic            f_valid_q;
  logic [15:0]     id_inst_q;
  logic [PC_W-1:0] id_pc1_q;
  logic            id_valid_q;
  logic            halted_q;

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] f_pc1_d;
  logic [PC_W-1:0] br_pc1_d;
  logic            redirect;

  assign pc_d     = pc_q + 1'b1;
  assign f_pc1_d  = f_pc_q + 1'b1;
  assign br_pc1_d = bus.br_target + 1'b1;

  // A redirect must address the target this very edge so its word is ready
  // for the next un-stalled edge; a stall re-reads the in-flight word.
  assign redirect      = (state_q == RUN) && bus.br_taken && !bus.halt;
  assign bus.imem_addr = redirect  ? bus.br_target :
                         bus.stall ? f_pc_q : pc_q;

  assign bus.id_inst  = id_inst_q;
  assign bus.id_pc1   = id_pc1_q;
  assign bus.id_valid = id_valid_q;
  assign bus.halted   = halted_q;

`ifdef IF_HALT_DETECT_EN
  logic park_q;   // HLT captured: stop issuing until a redirect
  logic is_hlt;
  assign is_hlt = f_valid_q && (bus.imem_rdata[15:14] == 2'b11) &&
                  (bus.imem_rdata[7:4] == 4'b1111);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      f_pc_q     <= '0;
      f_valid_q  <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc1_q   <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef IF_HALT_DETECT_EN
      park_q     <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      if (bus.halt) begin
        state_q    <= HALTED;
        halted_q   <= 1'b1;
        id_inst_q  <= NOP_INST;
        id_valid_q <= 1'b0;
      end else if (bus.br_taken) begin
        pc_q       <= br_pc1_d;
        f_pc_q     <= bus.br_target;
        f_valid_q  <= 1'b1;
        id_inst_q  <= NOP_INST;
        id_valid_q <= 1'b0;
`ifdef IF_HALT_DETECT_EN
        park_q     <= 1'b0;
`endif
      end else if (!bus.stall) begin
        id_inst_q  <= f_valid_q ? bus.imem_rdata : NOP_INST;
        id_valid_q <= f_valid_q;
        id_pc1_q   <= f_pc1_d;
`ifdef IF_HALT_DETECT_EN
        if (is_hlt) begin
          park_q    <= 1'b1;
          f_valid_q <= 1'b0;
        end else if (!park_q) begin
          f_pc_q    <= pc_q;
          f_valid_q <= 1'b1;
          pc_q      <= pc_d;
        end
`else
        f_pc_q    <= pc_q;
        f_valid_q <= 1'b1;
        pc_q      <= pc_d;
`endif
      end
    end
    // HALTED: everything holds until reset.
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hC070;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] br_target = 16'h0000;
  int          hlt_addr = -1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(16)) if0 ();
  fetch_stage_if #(.PC_W(16)) if1 ();

  assign if0.stall = stall;  assign if0.br_taken = br_taken;
  assign if0.halt = halt;    assign if0.br_target = br_target;
  assign if1.stall = stall;  assign if1.br_taken = br_taken;
  assign if1.halt = halt;    assign if1.br_target = br_target;

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INST(NOP)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  fetch_stage #(.PC_W(16), .RESET_PC(16'hFFFE), .NOP_INST(NOP)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  // Memory contents: imem[k] = 0x1000 + k, optionally one HLT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_addr >= 0 && int'(a) == hlt_addr) return 16'hC0F0;
    return 16'h1000 + a;
  endfunction

  function automatic bit is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  function automatic logic [15:0] rpc(input int i);
    return (i == 0) ? 16'h0000 : 16'hFFFE;
  endfunction

  logic [15:0] rd0, rd1;
  always @(posedge clk) begin
    rd0 <= mem_word(if0.imem_addr);
    rd1 <= mem_word(if1.imem_addr);
  end
  assign if0.imem_rdata = rd0;
  assign if1.imem_rdata = rd1;

  logic [15:0] o_inst [2];
  logic [15:0] o_pc1  [2];
  logic [15:0] o_addr [2];
  logic        o_valid[2];
  logic        o_halt [2];
  assign o_inst[0] = if0.id_inst;   assign o_inst[1] = if1.id_inst;
  assign o_pc1[0]  = if0.id_pc1;    assign o_pc1[1]  = if1.id_pc1;
  assign o_addr[0] = if0.imem_addr; assign o_addr[1] = if1.imem_addr;
  assign o_valid[0] = if0.id_valid; assign o_valid[1] = if1.id_valid;
  assign o_halt[0] = if0.halted;    assign o_halt[1] = if1.halted;

  bit detect_en;
`ifdef IF_HALT_DETECT_EN
  initial detect_en = 1'b1;
`else
  initial detect_en = 1'b0;
`endif

  // Reference model: next PC, address in flight, IF/ID contents.
  logic [15:0] m_pc[2], m_fa[2], m_inst[2], m_pc1[2];
  bit          m_fv[2], m_valid[2], m_halted[2], m_park[2], m_init[2];

  task automatic model_edge(input int i);
    logic [15:0] w;
    if (!rst_n) begin
      m_pc[i] = rpc(i); m_fa[i] = 16'h0; m_fv[i] = 0;
      m_inst[i] = NOP; m_pc1[i] = 16'h0; m_valid[i] = 0;
      m_halted[i] = 0; m_park[i] = 0; m_init[i] = 1;
    end else if (m_halted[i]) begin
    end else if (halt) begin
      m_halted[i] = 1; m_inst[i] = NOP; m_valid[i] = 0;
    end else if (br_taken) begin
      m_pc[i] = br_target + 16'd1; m_fa[i] = br_target; m_fv[i] = 1;
      m_inst[i] = NOP; m_valid[i] = 0; m_park[i] = 0;
    end else if (!stall) begin
      w = mem_word(m_fa[i]);
      m_inst[i]  = m_fv[i] ? w : NOP;
      m_valid[i] = m_fv[i];
      m_pc1[i]   = m_fa[i] + 16'd1;
      if (detect_en && m_fv[i] && is_hlt(w)) begin
        m_park[i] = 1; m_fv[i] = 0;
      end else if (!m_park[i]) begin
        m_fa[i] = m_pc[i]; m_fv[i] = 1; m_pc[i] = m_pc[i] + 16'd1;
      end
    end
  endtask

  task automatic chk(input string name, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, i, act, exp, $time);
    end
  endtask

  initial begin
    logic [15:0] ea;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (m_init[i]) begin
          chk("halted", i, o_halt[i], m_halted[i]);
          chk("id_valid", i, o_valid[i], m_valid[i]);
          chk("id_inst", i, o_inst[i], m_inst[i]);
          if (m_valid[i]) chk("id_pc1", i, o_pc1[i], m_pc1[i]);
          if (br_taken && !halt && !m_halted[i]) ea = br_target;
          else if (stall) ea = m_fa[i];
          else ea = m_pc[i];
          chk("imem_addr", i, o_addr[i], ea);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0; stall = 0; br_taken = 0; halt = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    logic [15:0] saved;

    // 1 + 4: reset and sequential fetch, with wrap on dut1
    do_reset();
    chk("t1_reset_valid", 0, o_valid[0], 1'b0);
    chk("t1_reset_inst", 0, o_inst[0], NOP);
    tick();
    chk("t1_e1_valid", 0, o_valid[0], 1'b0);
    tick();
    chk("t1_e2_inst", 0, o_inst[0], 16'h1000);
    chk("t1_e2_pc1", 0, o_pc1[0], 16'h0001);
    chk("t4_e2_pc1", 1, o_pc1[1], 16'hFFFF);
    tick();
    chk("t1_e3_inst", 0, o_inst[0], 16'h1001);
    chk("t4_e3_pc1", 1, o_pc1[1], 16'h0000);
    tick();
    chk("t1_e4_inst", 0, o_inst[0], 16'h1002);
    chk("t1_e4_pc1", 0, o_pc1[0], 16'h0003);
    chk("t4_e4_pc1", 1, o_pc1[1], 16'h0001);

    // 2: stall three cycles while id_inst = 1002
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_inst", 0, o_inst[0], 16'h1002);
      chk("t2_hold_pc1", 0, o_pc1[0], 16'h0003);
      chk("t2_addr", 0, o_addr[0], 16'h0003);
    end
    stall = 0;
    tick();
    chk("t2_after_inst", 0, o_inst[0], 16'h1003);
    chk("t2_after_pc1", 0, o_pc1[0], 16'h0004);

    // 3: redirect in the same cycle as a stall
    stall = 1; br_taken = 1; br_target = 16'h0040;
    tick();
    chk("t3_bubble_valid", 0, o_valid[0], 1'b0);
    chk("t3_bubble_inst", 0, o_inst[0], NOP);
    stall = 0; br_taken = 0;
    tick();
    chk("t3_target_inst", 0, o_inst[0], 16'h1040);
    chk("t3_target_pc1", 0, o_pc1[0], 16'h0041);
    chk("t3_target_valid", 0, o_valid[0], 1'b1);

    // 5: halt freezes the stage, redirects ignored, reset restarts
    halt = 1;
    tick();
    chk("t5_halted", 0, o_halt[0], 1'b1);
    chk("t5_valid", 0, o_valid[0], 1'b0);
    halt = 0;
    saved = o_addr[0];
    for (int k = 0; k < 10; k++) begin
      br_taken = 1; br_target = 16'($urandom_range(0, 4095));
      tick();
      chk("t5_addr_frozen", 0, o_addr[0], saved);
      chk("t5_still_halted", 0, o_halt[0], 1'b1);
    end
    br_taken = 0;
    do_reset();
    chk("t5_reset_halted", 0, o_halt[0], 1'b0);
    tick(); tick();
    chk("t5_restart_inst", 0, o_inst[0], 16'h1000);

`ifdef IF_HALT_DETECT_EN
    // 6: HLT at address 2 stops fetch until a redirect
    rst_n = 0; hlt_addr = 2;
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("t6_e2_inst", 0, o_inst[0], 16'h1000);
    tick();
    chk("t6_e3_inst", 0, o_inst[0], 16'h1001);
    tick();
    chk("t6_hlt_inst", 0, o_inst[0], 16'hC0F0);
    chk("t6_hlt_valid", 0, o_valid[0], 1'b1);
    saved = o_addr[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_nop_inst", 0, o_inst[0], NOP);
      chk("t6_nop_valid", 0, o_valid[0], 1'b0);
      chk("t6_addr_const", 0, o_addr[0], saved);
    end
    br_taken = 1; br_target = 16'h0010;
    tick();
    br_taken = 0;
    tick();
    chk("t6_rearm_inst", 0, o_inst[0], 16'h1010);
    chk("t6_rearm_pc1", 0, o_pc1[0], 16'h0011);
`endif

    // Randomized traffic against the model
    rst_n = 0; stall = 0; br_taken = 0; halt = 0;
    hlt_addr = detect_en ? 16'h25 : -1;
    tick(); tick();
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      halt      = ($urandom_range(0, 199) == 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      br_target = 16'($urandom_range(0, 127));
      stall     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
